// File: rtl/acc_demo_trim_sched.sv
// acc_demo_trim_sched: run-level sequencer for the ACC demo flag trim path.
// Arms PMT scanning on a clean flag boundary, counts flag periods, owns trim values.
module acc_demo_trim_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cfg_start_i,
    input  logic             cfg_abort_i,
    input  logic [CNT_W-1:0] cfg_period_num_i,
    input  logic [31:0]      cfg_timeout_i,
    input  logic [15:0]      cfg_trim_pose_i,
    input  logic [15:0]      cfg_trim_nege_i,
    input  logic             cfg_trim_update_i,
    input  logic             acc_demo_flag_i,
    output logic             pmt_scan_en_o,
    output logic [15:0]      acc_demo_trim_time_pose_o,
    output logic [15:0]      acc_demo_trim_time_nege_o,
    output logic             sched_busy_o,
    output logic             sched_done_o,
    output logic             sched_timeout_o,
    output logic [CNT_W-1:0] flag_cnt_o,
    output logic [31:0]      flag_period_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic               flag_prev_q, flag_prev_d;
    logic [15:0]        pose_q, pose_d;
    logic [15:0]        nege_q, nege_d;
    logic [15:0]        pend_pose_q, pend_pose_d;
    logic [15:0]        pend_nege_q, pend_nege_d;
    logic               pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [31:0]        tmo_q, tmo_d;
    logic [CNT_W-1:0]   flag_cnt_q, flag_cnt_d;
    logic [31:0]        flag_period_q, flag_period_d;
    logic [31:0]        per_cnt_q, per_cnt_d;
    logic [31:0]        gap_q, gap_d;
    logic               timeout_q, timeout_d;

    logic               rise;
    logic               live;
    logic               tmo_hit;
    logic               apply;
    logic [CNT_W-1:0]   cnt_inc;

    always_comb begin
        rise    = acc_demo_flag_i & ~flag_prev_q;
        live    = (state_q == S_ARM) || (state_q == S_RUN);
        tmo_hit = (tmo_q != 32'd0) && (gap_q >= tmo_q);
        apply   = pend_vld_q && live && !acc_demo_flag_i && !cfg_abort_i;
        cnt_inc = flag_cnt_q + CNT_W'(1);

        state_d       = state_q;
        flag_prev_d   = acc_demo_flag_i;
        pose_d        = pose_q;
        nege_d        = nege_q;
        pend_pose_d   = pend_pose_q;
        pend_nege_d   = pend_nege_q;
        pend_vld_d    = pend_vld_q;
        num_d         = num_q;
        tmo_d         = tmo_q;
        flag_cnt_d    = flag_cnt_q;
        flag_period_d = flag_period_q;
        timeout_d     = 1'b0;
        per_cnt_d     = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + 32'd1;
        gap_d         = gap_q;

        if (live && gap_q != '1) begin
            gap_d = gap_q + 32'd1;
        end

        if (apply) begin
            pose_d     = pend_pose_q;
            nege_d     = pend_nege_q;
            pend_vld_d = 1'b0;
        end

        // A newer request always wins over one still waiting for a low flag
        if (cfg_trim_update_i) begin
            if (state_q == S_IDLE) begin
                pose_d = cfg_trim_pose_i;
                nege_d = cfg_trim_nege_i;
            end else begin
                pend_pose_d = cfg_trim_pose_i;
                pend_nege_d = cfg_trim_nege_i;
                pend_vld_d  = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                pend_vld_d = 1'b0;
                if (cfg_start_i) begin
                    pose_d        = cfg_trim_pose_i;
                    nege_d        = cfg_trim_nege_i;
                    num_d         = cfg_period_num_i;
                    tmo_d         = cfg_timeout_i;
                    flag_cnt_d    = '0;
                    flag_period_d = '0;
                    gap_d         = 32'd1;
                    state_d       = (cfg_period_num_i == '0) ? S_DONE : S_ARM;
                end
            end
            S_ARM: begin
                if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (!acc_demo_flag_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rise) begin
                    flag_cnt_d = cnt_inc;
                    if (flag_cnt_q != '0) begin
                        flag_period_d = per_cnt_q;
                    end
                    per_cnt_d = 32'd1;
                    gap_d     = 32'd1;
                    if (cnt_inc == num_q) begin
                        state_d = S_DRAIN;
                    end
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (!acc_demo_flag_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cfg_abort_i && state_q != S_IDLE) begin
            state_d       = S_IDLE;
            timeout_d     = 1'b0;
            pend_vld_d    = 1'b0;
            flag_cnt_d    = flag_cnt_q;
            flag_period_d = flag_period_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            flag_prev_q   <= 1'b0;
            pose_q        <= '0;
            nege_q        <= '0;
            pend_pose_q   <= '0;
            pend_nege_q   <= '0;
            pend_vld_q    <= 1'b0;
            num_q         <= '0;
            tmo_q         <= '0;
            flag_cnt_q    <= '0;
            flag_period_q <= '0;
            per_cnt_q     <= '0;
            gap_q         <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            flag_prev_q   <= flag_prev_d;
            pose_q        <= pose_d;
            nege_q        <= nege_d;
            pend_pose_q   <= pend_pose_d;
            pend_nege_q   <= pend_nege_d;
            pend_vld_q    <= pend_vld_d;
            num_q         <= num_d;
            tmo_q         <= tmo_d;
            flag_cnt_q    <= flag_cnt_d;
            flag_period_q <= flag_period_d;
            per_cnt_q     <= per_cnt_d;
            gap_q         <= gap_d;
            timeout_q     <= timeout_d;
        end
    end

    // Pending trim shows on the outputs in the very cycle the flag is seen low
    assign acc_demo_trim_time_pose_o = apply ? pend_pose_q : pose_q;
    assign acc_demo_trim_time_nege_o = apply ? pend_nege_q : nege_q;

    assign pmt_scan_en_o   = (state_q == S_ARM) || (state_q == S_RUN) ||
                             (state_q == S_DRAIN);
    assign sched_busy_o    = (state_q != S_IDLE);
    assign sched_done_o    = (state_q == S_DONE);
    assign sched_timeout_o = timeout_q;
    assign flag_cnt_o      = flag_cnt_q;
    assign flag_period_o   = flag_period_q;

endmodule
